// File: rtl/lsu_xlen.sv
// lsu_xlen: multi-cycle load/store unit for XLEN=32/64 with byte lanes,
// load extension, misaligned/illegal detection and a memory-mapped outport.
module lsu_xlen #(
    parameter int          XLEN         = 32,
    parameter logic [15:0] OUTPORT_ADDR = 16'hfffc
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN/8-1:0] mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              outport_we,
    output logic [XLEN-1:0]   outport_data
);
    localparam int BEW  = XLEN / 8;
    localparam int OFFW = $clog2(BEW);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic            we_q;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] addr_q, wdata_q, rdata_q;
    logic            err_q, err_d;
    logic            accept, port_hit, cap;
    logic            illegal, misaligned, is_port;
    logic [OFFW-1:0] off;
    logic [XLEN-1:0] sh, load_ext;
    logic [7:0]      size_mask;
    logic            in_req, in_resp;

    assign accept = (state_q == IDLE) && req_valid;
    assign is_port = (req_addr == XLEN'(OUTPORT_ADDR));

    assign illegal = (req_funct3 == 3'b111)
                   || (req_we && req_funct3[2])
                   || ((XLEN == 32) && ((req_funct3 == 3'b011)
                                     || (req_funct3 == 3'b110)));

    // Size lives in funct3[1:0] for both signed and unsigned variants
    always_comb begin
        misaligned = 1'b0;
        unique case (req_funct3[1:0])
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = |req_addr[1:0];
            2'b11:   misaligned = |req_addr[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        port_hit = 1'b0;
        cap      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    err_d = 1'b0;
                    if (illegal || misaligned) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else if (req_we && is_port) begin
                        port_hit = 1'b1;
                        state_d  = RESP;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (mem_ready) begin
                    if (we_q) begin
                        state_d = RESP;
                    end else if (mem_rvalid) begin
                        cap     = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    cap     = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            f3_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            outport_we   <= 1'b0;
            outport_data <= '0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            outport_we <= port_hit;
            if (accept) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                rdata_q <= '0;
            end
            if (port_hit) outport_data <= req_wdata;
            if (cap)      rdata_q      <= load_ext;
        end
    end

    assign off = addr_q[OFFW-1:0];
    assign sh  = mem_rdata >> {off, 3'b000};

    always_comb begin
        load_ext = '0;
        unique case (f3_q)
            3'b000:  load_ext = XLEN'($signed(sh[7:0]));
            3'b001:  load_ext = XLEN'($signed(sh[15:0]));
            3'b010:  load_ext = XLEN'($signed(sh[31:0]));
            3'b011:  load_ext = sh;
            3'b100:  load_ext = XLEN'(sh[7:0]);
            3'b101:  load_ext = XLEN'(sh[15:0]);
            3'b110:  load_ext = XLEN'(sh[31:0]);
            default: load_ext = '0;
        endcase
    end

    always_comb begin
        size_mask = 8'h01;
        unique case (f3_q[1:0])
            2'b00:   size_mask = 8'h01;
            2'b01:   size_mask = 8'h03;
            2'b10:   size_mask = 8'h0f;
            default: size_mask = 8'hff;
        endcase
    end

    assign in_req  = (state_q == REQ);
    assign in_resp = (state_q == RESP);

    assign req_ready  = (state_q == IDLE);
    assign mem_valid  = in_req;
    assign mem_we     = in_req & we_q;
    assign mem_addr   = in_req ? {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}} : '0;
    assign mem_be     = in_req ? (BEW'(size_mask) << off) : '0;
    assign mem_wdata  = in_req ? (wdata_q << {off, 3'b000}) : '0;
    assign resp_valid = in_resp;
    assign resp_err   = in_resp & err_q;
    assign resp_rdata = in_resp ? rdata_q : '0;
endmodule
